uart_tx_fifo: RTL and testbench

//  UART transmitter with a small input FIFO. It takes bytes from on-chip logic

---
 rtl/uart_tx_fifo.sv | 151 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small circular FIFO through a valid/ready handshake.
// Frames are start, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    data,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int CCW = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]  FULL      = CW'(FIFO_DEPTH);
    localparam logic [CCW-1:0] CNT_LAST  = CCW'(CPB - 1);
    localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t         state, state_n;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [7:0]     head;
    logic           push, pop;
    logic [7:0]     shift, shift_n;
    logic           par_bit, par_n;
    logic [2:0]     bit_idx, bit_idx_n;
    logic [CCW-1:0] clk_cnt;
    logic           bit_end;
    logic           tx_n;

    assign data_ready = (fifo_count != FULL);
    assign push       = data_valid & data_ready;
    assign head       = mem[rd_ptr];
    assign bit_end    = (clk_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_comb begin
        state_n   = state;
        tx_n      = tx;
        shift_n   = shift;
        par_n     = par_bit;
        bit_idx_n = bit_idx;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                tx_n = 1'b1;
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    shift_n = head;
                    par_n   = (PARITY == 1) ? ~^head : ^head;
                    tx_n    = 1'b0;
                    state_n = S_START;
                end
            end
            S_START: if (bit_end) begin
                state_n   = S_DATA;
                bit_idx_n = '0;
                tx_n      = shift[0];
            end
            S_DATA: if (bit_end) begin
                if (bit_idx != 3'd7) begin
                    bit_idx_n = bit_idx + 3'd1;
                    shift_n   = {1'b0, shift[7:1]};
                    tx_n      = shift[1];
                end else if (PARITY != 0) begin
                    state_n = S_PAR;
                    tx_n    = par_bit;
                end else begin
                    state_n   = S_STOP;
                    bit_idx_n = '0;
                    tx_n      = 1'b1;
                end
            end
            S_PAR: if (bit_end) begin
                state_n   = S_STOP;
                bit_idx_n = '0;
                tx_n      = 1'b1;
            end
            S_STOP: if (bit_end) begin
                // bit_idx counts stop bits here; chain straight into the next frame
                if (bit_idx != STOP_LAST) begin
                    bit_idx_n = bit_idx + 3'd1;
                end else if (fifo_count != '0) begin
                    pop     = 1'b1;
                    shift_n = head;
                    par_n   = (PARITY == 1) ? ~^head : ^head;
                    tx_n    = 1'b0;
                    state_n = S_START;
                end else begin
                    state_n = S_IDLE;
                    tx_n    = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            shift   <= '0;
            par_bit <= 1'b0;
            bit_idx <= '0;
            clk_cnt <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            tx      <= tx_n;
            shift   <= shift_n;
            par_bit <= par_n;
            bit_idx <= bit_idx_n;
            clk_cnt <= (state == S_IDLE || bit_end) ? '0 : clk_cnt + CCW'(1);
            busy    <= (state != S_IDLE) || (fifo_count != '0);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three parity/stop configurations, each line compared
// cycle by cycle against a waveform built from the byte stream.
module tb_uart_tx_fifo;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din [3];
    logic       vin [3];
    logic       rdy [3];
    logic       txo [3];
    logic       bsy [3];
    logic [2:0] cnt [3];

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];
    bit saw_full;

    always #5 clk = ~clk;

    // u0: no parity, 1 stop; u1: even parity, 2 stop; u2: odd parity, 1 stop
    uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .FIFO_DEPTH(4),
                   .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .data(din[0]), .data_valid(vin[0]),
        .data_ready(rdy[0]), .tx(txo[0]), .busy(bsy[0]), .fifo_count(cnt[0]));
    uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .FIFO_DEPTH(4),
                   .PARITY(2), .STOP_BITS(2)) u1 (
        .clk(clk), .rst_n(rst_n), .data(din[1]), .data_valid(vin[1]),
        .data_ready(rdy[1]), .tx(txo[1]), .busy(bsy[1]), .fifo_count(cnt[1]));
    uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .FIFO_DEPTH(4),
                   .PARITY(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .data(din[2]), .data_valid(vin[2]),
        .data_ready(rdy[2]), .tx(txo[2]), .busy(bsy[2]), .fifo_count(cnt[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic [7:0] d, input logic v);
        din[s] = d;
        vin[s] = v;
    endtask

    // Expected line: start 0, data LSB first, optional parity, stop 1s; CPB cycles per bit.
    task automatic run_frames(input int s, input int par, input int stp, input int max_cyc);
        int n = 0;
        bit b [$];
        logic [7:0] v;
        int ones;
        foreach (exp_q[i]) begin
            v = exp_q[i];
            b.delete();
            b.push_back(1'b0);
            for (int j = 0; j < 8; j++) b.push_back(v[j]);
            if (par != 0) begin
                ones = $countones(v);
                b.push_back((par == 2) ? bit'(ones % 2) : bit'(1 - ones % 2));
            end
            repeat (stp) b.push_back(1'b1);
            foreach (b[k]) begin
                repeat (CPB) begin
                    if (n == max_cyc) return;
                    chk($sformatf("tx_u%0d_byte%0d_bit%0d", s, i, k), 32'(txo[s]), 32'(b[k]));
                    chk($sformatf("busy_u%0d", s), 32'(bsy[s]), 32'd1);
                    n++;
                    step();
                end
            end
        end
    endtask

    // Pushes exp_q with valid held, while checking the serial stream from the first pop.
    task automatic send_and_check(input int s, input int par, input int stp);
        chk($sformatf("cnt_empty_u%0d", s), 32'(cnt[s]), 32'd0);
        drive(s, exp_q[0], 1'b1);
        step();
        chk($sformatf("cnt_one_u%0d", s), 32'(cnt[s]), 32'd1);
        chk($sformatf("tx_idle_before_pop_u%0d", s), 32'(txo[s]), 32'd1);
        fork
            begin
                bit acc;
                int n;
                for (int i = 1; i < exp_q.size(); i++) begin
                    drive(s, exp_q[i], 1'b1);
                    acc = 1'b0;
                    n = 0;
                    while (!acc && n < 2000) begin
                        acc = rdy[s];
                        if (!rdy[s]) saw_full = 1'b1;
                        chk($sformatf("cnt_bound_u%0d", s), 32'(cnt[s] <= 3'd4), 32'd1);
                        step();
                        n++;
                    end
                    if (!acc) chk($sformatf("push_timeout_u%0d", s), 32'd0, 32'd1);
                end
                drive(s, 8'h00, 1'b0);
            end
            begin
                step();
                run_frames(s, par, stp, 1 << 30);
            end
        join
        chk($sformatf("busy_tail_u%0d", s), 32'(bsy[s]), 32'd1);
        chk($sformatf("tx_after_u%0d", s), 32'(txo[s]), 32'd1);
        step();
        chk($sformatf("busy_low_u%0d", s), 32'(bsy[s]), 32'd0);
        chk($sformatf("cnt_drained_u%0d", s), 32'(cnt[s]), 32'd0);
    endtask

    initial begin
        for (int s = 0; s < 3; s++) drive(s, 8'h00, 1'b0);

        // Reset and idle
        repeat (3) step();
        for (int s = 0; s < 3; s++) begin
            chk("rst_tx", 32'(txo[s]), 32'd1);
            chk("rst_busy", 32'(bsy[s]), 32'd0);
            chk("rst_ready", 32'(rdy[s]), 32'd1);
            chk("rst_cnt", 32'(cnt[s]), 32'd0);
        end
        rst_n = 1'b1;
        repeat (50) begin
            step();
            chk("idle_tx", 32'(txo[0]), 32'd1);
            chk("idle_busy", 32'(bsy[0]), 32'd0);
            chk("idle_ready", 32'(rdy[0]), 32'd1);
            chk("idle_cnt", 32'(cnt[0]), 32'd0);
        end

        // Single byte
        exp_q = '{8'h55};
        send_and_check(0, 0, 1);

        // Held valid, 6 bytes into a 4-deep FIFO
        saw_full = 1'b0;
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        send_and_check(0, 0, 1);
        chk("ready_dropped_when_full", 32'(saw_full), 32'd1);

        // Parity and stop-bit variants, plus random bytes
        exp_q = '{8'h07};
        send_and_check(1, 2, 2);
        exp_q = '{8'h07};
        send_and_check(2, 1, 1);
        exp_q = '{};
        repeat (3) exp_q.push_back(8'($urandom));
        send_and_check(1, 2, 2);
        exp_q = '{};
        repeat (3) exp_q.push_back(8'($urandom));
        send_and_check(2, 1, 1);

        // Back-to-back 0xFF then 0x00, then a random burst
        exp_q = '{8'hFF, 8'h00};
        send_and_check(0, 0, 1);
        exp_q = '{};
        repeat (5) exp_q.push_back(8'($urandom));
        send_and_check(0, 0, 1);

        // Reset mid-frame
        exp_q = '{8'h3C, 8'h81};
        drive(0, 8'h3C, 1'b1);
        step();
        drive(0, 8'h81, 1'b1);
        step();
        drive(0, 8'h00, 1'b0);
        run_frames(0, 0, 1, 35);
        rst_n = 1'b0;
        #1;
        chk("abort_tx", 32'(txo[0]), 32'd1);
        chk("abort_cnt", 32'(cnt[0]), 32'd0);
        chk("abort_busy", 32'(bsy[0]), 32'd0);
        chk("abort_ready", 32'(rdy[0]), 32'd1);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (30) begin
            step();
            chk("post_rst_tx", 32'(txo[0]), 32'd1);
            chk("post_rst_busy", 32'(bsy[0]), 32'd0);
            chk("post_rst_cnt", 32'(cnt[0]), 32'd0);
        end
        exp_q = '{8'(($urandom))};
        send_and_check(0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
